mips_boot_memory: RTL
=====================

Name: mips_boot_memory

Overview:
- Unified instruction/data memory that sits directly under mips_processor on the addr/memread/memwrite/writedata/memdata bus.
- Contains a byte-stream program loader. After reset it holds the processor stalled, accepts a program image one byte at a time, packs the bytes into big-endian words and writes them from word 0 upward.
- Once loading finishes, it releases the processor and serves it as a synchronous word RAM.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words; power of two, at least 4
IDX_W, $clog2(DEPTH_WORDS), word-index width (derived; do not override)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
addr  input  32  processor byte address; word index = addr[IDX_W+1:2]
memread  input  1  processor read strobe
memwrite  input  1  processor write strobe
writedata  input  32  processor write data
memdata  output  32  registered read data to processor
ld_valid  input  1  loader byte valid
ld_byte  input  8  loader byte
ld_last  input  1  marks final byte of image; qualified by ld_valid
ld_ready  output  1  loader may present a byte (high only in LOAD)
cpu_hold  output  1  high while loading; top level ORs it into the processor reset
words_loaded  output  IDX_W+1  count of words written by the loader
load_err  output  1  sticky: image exceeded DEPTH_WORDS

Behaviour:
- FSM has two states, LOAD and RUN. Reset (reset=0) forces LOAD immediately.
- Asynchronous reset clears all registers: memdata=0, words_loaded=0, load_err=0, byte counter=0, word pointer=0, assembly register=0. RAM contents are not cleared.
- ld_ready = (state==LOAD) and cpu_hold = (state==LOAD). Both read 1 during and after reset.
- LOAD, byte accept:
  - A byte is accepted on a rising edge with ld_valid=1.
  - Byte k of each word (k=0..3) lands in bits [31-8k:24-8k]; the first byte goes to the MSB.
- LOAD, word write:
  - On accepting byte 3, the assembled word is written to RAM[pointer] on that same edge.
  - The pointer and words_loaded then increment, and the byte counter returns to 0.
- LOAD, end of image:
  - If an accepted byte has ld_last=1, the current word is written with any remaining low bytes zero-filled, words_loaded increments, and the state moves to RUN on that edge.
  - If ld_last arrives on byte 3, exactly one word is written; there is no extra empty word.
- LOAD, overflow:
  - Once the pointer reaches DEPTH_WORDS, further word writes are dropped and load_err is set.
  - The pointer and words_loaded saturate at DEPTH_WORDS. Bytes are still accepted, and ld_last still moves the state to RUN.
- LOAD, processor bus: memread and memwrite are ignored and memdata holds its value.
- RUN, read: with memread=1 on an edge, memdata <= RAM[addr[IDX_W+1:2]]. Latency is one edge. memdata holds otherwise.
- RUN, write: with memwrite=1 on an edge, RAM[index] <= writedata.
- RUN, read and write together:
  - Both happen on the same edge.
  - memdata returns the OLD contents (read-before-write).
  - The written value is visible on the next read.
- RUN, address handling:
  - addr[1:0] is ignored; there are no byte enables and misalignment is not flagged.
  - addr bits above IDX_W+1 are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- RUN, loader inputs: ld_valid, ld_byte and ld_last are ignored. Only reset returns the FSM to LOAD.
- Reset mid-load:
  - Returns to LOAD with pointer 0, byte counter 0, words_loaded 0 and load_err 0.
  - A partial word is discarded; RAM keeps whatever was already written.
- Reset mid-run: memdata=0 and cpu_hold=1 immediately, asynchronously.
- Implementation: RAM is a reg array sized DEPTH_WORDS with a single write port muxed by state, so it is inferable as block RAM with a synchronous read.

Test Plan:
- Load 8 bytes 20,08,00,05,AC,08,00,3C with ld_last on the final byte -> words_loaded=2, RAM[0]=20080005, RAM[1]=AC08003C. cpu_hold falls on the edge accepting byte 8 and ld_ready goes 0.
- Load 6 bytes 11,22,33,44,55,66 with ld_last on byte 6 -> RAM[1]=55660000, words_loaded=2, state RUN.
- RUN after the first load: memread=1, addr=00000004 -> memdata=AC08003C one edge later. Then memwrite=1, addr=0000003C, writedata=DEADBEEF, followed by a read of 3C -> DEADBEEF. A read of addr=0000013C (wraps with DEPTH 64) -> DEADBEEF.
- Simultaneous memread=1 and memwrite=1 at addr=00000000 with writedata=12345678 -> memdata=20080005 (old). A following read -> 12345678.
- DEPTH_WORDS=4: load 20 bytes with ld_last on byte 20 -> words_loaded=4, load_err=1, RAM[0..3] hold the first 16 bytes, state RUN.
- Assert reset for 1 cycle after 3 bytes of a load -> cpu_hold=1, words_loaded=0, and the next 4 bytes land in RAM[0]. During LOAD, memwrite=1 leaves RAM unchanged and memdata stays 0.

Source files
------------

// File: rtl/mips_boot_memory.sv
`default_nettype none
// ============================================================================
// Module      : mips_boot_memory
// Description : Unified instruction/data word RAM for mips_processor with a
//               built-in byte-stream program loader. After reset the loader
//               owns the RAM and holds the processor stalled; it packs bytes
//               big-endian into words written from word 0 upward. When the
//               last byte arrives the processor is released and the block
//               behaves as a synchronous-read, read-before-write word RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_boot_memory #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active-low
    // processor bus
    input  logic [31:0]      addr,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [31:0]      writedata,
    output logic [31:0]      memdata,
    // byte-stream loader
    input  logic             ld_valid,
    input  logic [7:0]       ld_byte,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             cpu_hold,
    output logic [IDX_W:0]   words_loaded,
    output logic             load_err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Pointer value meaning "RAM is full"; the pointer saturates here.
    localparam logic [IDX_W:0] PTR_FULL = (IDX_W+1)'(DEPTH_WORDS);

    // ------------------------------------------------------------------------
    // Storage and registers
    // ------------------------------------------------------------------------
    logic [31:0]      ram [DEPTH_WORDS];

    logic [0:0]       state;
    logic [1:0]       byte_cnt;     // position of next byte within the word
    logic [IDX_W:0]   ptr;          // next word to be written by the loader
    logic [23:0]      asm_word;     // bytes 0..2 of the word being assembled

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic             is_load;
    logic             accept;
    logic             word_done;
    logic             full;
    logic             ld_we;
    logic             cpu_we;
    logic             cpu_re;
    logic [IDX_W-1:0] cpu_idx;
    logic [31:0]      packed_word;
    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [31:0]      ram_wdata;

    // Low address bits and bits above the RAM window do not select anything.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:IDX_W+2], addr[1:0]};

    assign is_load   = (state == ST_LOAD);
    assign accept    = is_load & ld_valid;
    // A word is complete on its 4th byte, or early when the image ends.
    assign word_done = accept & ((byte_cnt == 2'd3) | ld_last);
    assign full      = (ptr == PTR_FULL);
    // Once full, completed words are dropped rather than wrapping.
    assign ld_we     = word_done & ~full;

    assign cpu_we    = ~is_load & memwrite;
    assign cpu_re    = ~is_load & memread;
    assign cpu_idx   = addr[IDX_W+1:2];

    assign ld_ready     = is_load;
    assign cpu_hold     = is_load;
    assign words_loaded = ptr;

    // Merge the incoming byte into the assembly word; the bytes below the
    // current position are zero so an early-ended word is already zero-filled.
    always_comb begin
        packed_word = 32'h0;
        case (byte_cnt)
            2'd0:    packed_word = {ld_byte, 24'h0};
            2'd1:    packed_word = {asm_word[23:16], ld_byte, 16'h0};
            2'd2:    packed_word = {asm_word[23:8], ld_byte, 8'h0};
            default: packed_word = {asm_word[23:0], ld_byte};
        endcase
    end

    // Single RAM write port, owned by the loader in LOAD and the CPU in RUN.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = 32'h0;
        if (is_load) begin
            ram_we    = ld_we;
            ram_waddr = ptr[IDX_W-1:0];
            ram_wdata = packed_word;
        end else begin
            ram_we    = cpu_we;
            ram_waddr = cpu_idx;
            ram_wdata = writedata;
        end
    end

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Loader FSM: byte assembly, word pointer, overflow flag, LOAD->RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_LOAD;
            byte_cnt <= 2'd0;
            ptr      <= '0;
            asm_word <= 24'h0;
            load_err <= 1'b0;
        end else if (accept) begin
            if (word_done) begin
                byte_cnt <= 2'd0;
                asm_word <= 24'h0;
                if (full) begin
                    load_err <= 1'b1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end else begin
                byte_cnt <= byte_cnt + 2'd1;
                asm_word <= packed_word[31:8];
            end
            if (ld_last) begin
                state <= ST_RUN;
            end
        end
    end

    // Registered CPU read; sees pre-write contents on a simultaneous write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memdata <= 32'h0;
        end else if (cpu_re) begin
            memdata <= ram[cpu_idx];
        end
    end

    // RAM array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

endmodule
`default_nettype wire
